irrigation_zone_scheduler: RTL and testbench

//  Multi-zone successor to the single-line irrigation controller: serves N_ZONES sensor zones over one shared water line.

---
 rtl/irrigation_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/irrigation_zone_scheduler.sv | 178 +++++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation zone scheduler.
//  - state_t : scheduler states, numeric values visible on state_o
//  - mode_t  : irrigation mode latched at grant time
//  - SEC_W   : width of the seconds-remaining counter
//  - ZONE_W  : width of zone indices (covers up to 8 zones)
package irrigation_pkg;

    localparam int SEC_W  = 7;
    localparam int ZONE_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_CLEAN    = 3'd3,
        ST_ALERT    = 3'd4
    } state_t;

    typedef enum logic {
        MODE_SPRINKLER = 1'b0,
        MODE_DRIP      = 1'b1
    } mode_t;

    // Converts a duration parameter in seconds to the counter width.
    function automatic logic [SEC_W-1:0] to_sec(input int unsigned s);
        return SEC_W'(s);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after ptr, wrapping past N-1 to 0.
//  req         in  N       request vector
//  ptr         in  ZONE_W  highest-priority index this round (must be < N)
//  grant_valid out 1       some request is asserted
//  grant_idx   out ZONE_W  index of the granted request (0 when none)
module rr_arbiter
    import irrigation_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      req,
    input  logic [ZONE_W-1:0] ptr,
    output logic              grant_valid,
    output logic [ZONE_W-1:0] grant_idx
);

    // Rotating a doubled copy puts req[ptr] at bit 0, so the lowest set bit
    // of the low N bits is the winner, offset back by ptr.
    logic [2*N-1:0] req_rot;
    assign req_rot = {req, req} >> ptr;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Descending scan: the smallest offset is assigned last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_valid = 1'b1;
                grant_idx   = ZONE_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation scheduler sharing one water line.
// Grants one dry zone at a time (round-robin) and runs FILL -> IRRIGATE -> CLEAN,
// parking in ALERT if pesticide is missing at the end of FILL.
//  clk_50mhz      in  clock, rising edge
//  init_pulse     in  synchronous active-high reset
//  tick_1hz_i     in  one-cycle seconds strobe
//  enable_i       in  allow new grants
//  zone_mask_i    in  per-zone request enable
//  soil_dry_i     in  per-zone soil-dry sensor (request)
//  air_dry_i      in  per-zone air-dry sensor  (drip mode with temp_hot_i)
//  temp_hot_i     in  per-zone high-temperature sensor
//  pesticide_ok_i in  pesticide present
//  state_o        out current state (IDLE=0 FILL=1 IRRIGATE=2 CLEAN=3 ALERT=4)
//  active_zone_o  out granted zone, valid while busy_o
//  mode_o         out 0 sprinkler / 1 drip, latched at grant
//  valve_o        out one-hot valve of the active zone during IRRIGATE
//  fill_o/clean_o out high in FILL / CLEAN
//  remaining_o    out seconds left in the timed state, 0 otherwise
//  alert_np_o     out high in ALERT
//  busy_o         out state_o != IDLE
//  done_o         out one-cycle pulse on CLEAN -> IDLE
module irrigation_zone_scheduler
    import irrigation_pkg::*;
#(
    parameter int N_ZONES     = 4,
    parameter int FILL_S      = 5,
    parameter int SPRINKLER_S = 20,
    parameter int DRIP_S      = 40,
    parameter int CLEAN_S     = 3
) (
    input  logic               clk_50mhz,
    input  logic               init_pulse,
    input  logic               tick_1hz_i,
    input  logic               enable_i,
    input  logic [N_ZONES-1:0] zone_mask_i,
    input  logic [N_ZONES-1:0] soil_dry_i,
    input  logic [N_ZONES-1:0] air_dry_i,
    input  logic [N_ZONES-1:0] temp_hot_i,
    input  logic               pesticide_ok_i,
    output logic [2:0]         state_o,
    output logic [ZONE_W-1:0]  active_zone_o,
    output logic               mode_o,
    output logic [N_ZONES-1:0] valve_o,
    output logic               fill_o,
    output logic               clean_o,
    output logic [SEC_W-1:0]   remaining_o,
    output logic               alert_np_o,
    output logic               busy_o,
    output logic               done_o
);

    state_t             state, nxt_state;
    logic [SEC_W-1:0]   rem, nxt_rem;
    logic [ZONE_W-1:0]  ptr, nxt_ptr;
    logic [ZONE_W-1:0]  zone, nxt_zone;
    mode_t              mode, nxt_mode;
    logic               nxt_done;

    logic [N_ZONES-1:0] req;
    logic [N_ZONES-1:0] drip_sh;
    logic               grant_valid;
    logic [ZONE_W-1:0]  grant_idx;
    logic               expire;
    logic [SEC_W-1:0]   irr_dur;

    assign req     = zone_mask_i & soil_dry_i;
    assign drip_sh = (air_dry_i & temp_hot_i) >> grant_idx;
    assign expire  = tick_1hz_i && (rem == SEC_W'(1));
    assign irr_dur = (mode == MODE_DRIP) ? to_sec(DRIP_S) : to_sec(SPRINKLER_S);

    rr_arbiter #(.N(N_ZONES)) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        nxt_state = state;
        nxt_rem   = rem;
        nxt_ptr   = ptr;
        nxt_zone  = zone;
        nxt_mode  = mode;
        nxt_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Sensors, mask and enable only matter here; later changes cannot
                // disturb a running zone.
                if (enable_i && grant_valid) begin
                    nxt_state = ST_FILL;
                    nxt_rem   = to_sec(FILL_S);
                    nxt_zone  = grant_idx;
                    nxt_mode  = mode_t'(drip_sh[0]);
                    nxt_ptr   = (grant_idx == ZONE_W'(N_ZONES - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            ST_FILL: begin
                if (expire) begin
                    if (pesticide_ok_i) begin
                        nxt_state = ST_IRRIGATE;
                        nxt_rem   = irr_dur;
                    end else begin
                        nxt_state = ST_ALERT;
                        nxt_rem   = '0;
                    end
                end else if (tick_1hz_i) begin
                    nxt_rem = rem - 1'b1;
                end
            end
            ST_IRRIGATE: begin
                if (expire) begin
                    nxt_state = ST_CLEAN;
                    nxt_rem   = to_sec(CLEAN_S);
                end else if (tick_1hz_i) begin
                    nxt_rem = rem - 1'b1;
                end
            end
            ST_CLEAN: begin
                if (expire) begin
                    nxt_state = ST_IDLE;
                    nxt_rem   = '0;
                    nxt_done  = 1'b1;
                end else if (tick_1hz_i) begin
                    nxt_rem = rem - 1'b1;
                end
            end
            ST_ALERT: begin
                // Timer frozen at 0; only pesticide arrival releases the zone.
                if (pesticide_ok_i) begin
                    nxt_state = ST_IRRIGATE;
                    nxt_rem   = irr_dur;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_rem   = '0;
            end
        endcase
    end

    // Decoded outputs are registered from the next-state values so they change
    // on the same edge as state_o.
    always_ff @(posedge clk_50mhz) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block with no edge in the sensitivity list.
        if (init_pulse) begin
            state      <= ST_IDLE;
            rem        <= '0;
            ptr        <= '0;
            zone       <= '0;
            mode       <= MODE_SPRINKLER;
            valve_o    <= '0;
            fill_o     <= 1'b0;
            clean_o    <= 1'b0;
            alert_np_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            state      <= nxt_state;
            rem        <= nxt_rem;
            ptr        <= nxt_ptr;
            zone       <= nxt_zone;
            mode       <= nxt_mode;
            valve_o    <= (nxt_state == ST_IRRIGATE) ? (N_ZONES'(1) << nxt_zone) : '0;
            fill_o     <= (nxt_state == ST_FILL);
            clean_o    <= (nxt_state == ST_CLEAN);
            alert_np_o <= (nxt_state == ST_ALERT);
            busy_o     <= (nxt_state != ST_IDLE);
            done_o     <= nxt_done;
        end
    end

    assign state_o       = state;
    assign remaining_o   = rem;
    assign active_zone_o = zone;
    assign mode_o        = mode;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
module tb_irrigation_zone_scheduler;

    localparam int N      = 4;
    localparam int FILL   = 5;
    localparam int SPR    = 20;
    localparam int DRIP   = 40;
    localparam int CLN    = 3;

    logic         clk_50mhz = 1'b0;
    logic         init_pulse;
    logic         tick_1hz_i;
    logic         enable_i;
    logic [N-1:0] zone_mask_i;
    logic [N-1:0] soil_dry_i;
    logic [N-1:0] air_dry_i;
    logic [N-1:0] temp_hot_i;
    logic         pesticide_ok_i;
    logic [2:0]   state_o;
    logic [2:0]   active_zone_o;
    logic         mode_o;
    logic [N-1:0] valve_o;
    logic         fill_o;
    logic         clean_o;
    logic [6:0]   remaining_o;
    logic         alert_np_o;
    logic         busy_o;
    logic         done_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    irrigation_zone_scheduler #(
        .N_ZONES(N), .FILL_S(FILL), .SPRINKLER_S(SPR), .DRIP_S(DRIP), .CLEAN_S(CLN)
    ) dut (
        .clk_50mhz      (clk_50mhz),
        .init_pulse     (init_pulse),
        .tick_1hz_i     (tick_1hz_i),
        .enable_i       (enable_i),
        .zone_mask_i    (zone_mask_i),
        .soil_dry_i     (soil_dry_i),
        .air_dry_i      (air_dry_i),
        .temp_hot_i     (temp_hot_i),
        .pesticide_ok_i (pesticide_ok_i),
        .state_o        (state_o),
        .active_zone_o  (active_zone_o),
        .mode_o         (mode_o),
        .valve_o        (valve_o),
        .fill_o         (fill_o),
        .clean_o        (clean_o),
        .remaining_o    (remaining_o),
        .alert_np_o     (alert_np_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase name, seconds left, whose turn is next.
    // Phase numbers are the values the display shows on state_o.
    int m_phase, m_left, m_next, m_zone, m_drip, m_done;

    function automatic int irrigate_len();
        return m_drip ? DRIP : SPR;
    endfunction

    task automatic model_step();
        m_done = 0;
        if (init_pulse) begin
            m_phase = 0; m_left = 0; m_next = 0; m_zone = 0; m_drip = 0;
            return;
        end
        case (m_phase)
            0: if (enable_i) begin
                for (int k = 0; k < N; k++) begin
                    int z;
                    z = (m_next + k) % N;
                    if (zone_mask_i[z] && soil_dry_i[z]) begin
                        m_zone  = z;
                        m_drip  = (air_dry_i[z] && temp_hot_i[z]) ? 1 : 0;
                        m_next  = (z + 1) % N;
                        m_phase = 1;
                        m_left  = FILL;
                        break;
                    end
                end
            end
            1: if (tick_1hz_i) begin
                if (m_left > 1) m_left--;
                else if (pesticide_ok_i) begin m_phase = 2; m_left = irrigate_len(); end
                else begin m_phase = 4; m_left = 0; end
            end
            2: if (tick_1hz_i) begin
                if (m_left > 1) m_left--;
                else begin m_phase = 3; m_left = CLN; end
            end
            3: if (tick_1hz_i) begin
                if (m_left > 1) m_left--;
                else begin m_phase = 0; m_left = 0; m_done = 1; end
            end
            4: if (pesticide_ok_i) begin m_phase = 2; m_left = irrigate_len(); end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("state", state_o, m_phase);
        check("remaining", remaining_o, m_left);
        check("valve", valve_o, (m_phase == 2) ? (1 << m_zone) : 0);
        check("fill", fill_o, m_phase == 1);
        check("clean", clean_o, m_phase == 3);
        check("alert", alert_np_o, m_phase == 4);
        check("busy", busy_o, m_phase != 0);
        check("done", done_o, m_done);
        if (m_phase != 0) begin
            check("zone", active_zone_o, m_zone);
            check("mode", mode_o, m_drip);
        end
    endtask

    // Inputs change only at the falling edge; outputs are compared there too.
    task automatic step();
        @(posedge clk_50mhz);
        model_step();
        @(negedge clk_50mhz);
        compare_all();
        cyc++;
    endtask

    task automatic do_reset();
        init_pulse = 1'b1;
        tick_1hz_i = 1'b0;
        step();
        init_pulse = 1'b0;
    endtask

    task automatic set_zones(input logic [N-1:0] mask, soil, air, temp);
        zone_mask_i = mask; soil_dry_i = soil; air_dry_i = air; temp_hot_i = temp;
    endtask

    // Runs until done_o, counting the ticks spent in each phase.
    task automatic run_to_done(input int tick_every, input logic [N-1:0] valve_exp,
                               output int fill_t, output int irr_t, output int cln_t,
                               output logic seen);
        fill_t = 0; irr_t = 0; cln_t = 0; seen = 1'b0;
        for (int i = 0; i < 800 && !seen; i++) begin
            tick_1hz_i = (cyc % tick_every == 0);
            if (tick_1hz_i && fill_o) fill_t++;
            if (tick_1hz_i && valve_o == valve_exp) irr_t++;
            if (tick_1hz_i && clean_o) cln_t++;
            step();
            if (done_o) seen = 1'b1;
        end
    endtask

    task automatic grant_order(input int n, output int got[$]);
        logic prev;
        got = {};
        for (int i = 0; i < 1000 && got.size() < n; i++) begin
            tick_1hz_i = 1'b1;
            prev = busy_o;
            step();
            if (!prev && busy_o) got.push_back(int'(active_zone_o));
        end
    endtask

    task automatic run_until_phase(input int ph, input int tick_every);
        int i;
        for (i = 0; i < 500 && m_phase != ph; i++) begin
            tick_1hz_i = (cyc % tick_every == 0);
            step();
        end
        check("reach_phase", m_phase, ph);
    endtask

    initial begin
        int   f_t, i_t, c_t;
        logic seen;
        int   got[$];
        int   exp_a[5];
        int   exp_b[4];

        init_pulse = 1'b1; tick_1hz_i = 1'b0; enable_i = 1'b0;
        pesticide_ok_i = 1'b1;
        set_zones('0, '0, '0, '0);
        m_phase = 0; m_left = 0; m_next = 0; m_zone = 0; m_drip = 0; m_done = 0;
        @(negedge clk_50mhz);

        // Reset state
        do_reset();
        check("rst_state", state_o, 0);
        check("rst_valve", valve_o, 0);

        // Single sprinkler zone 2
        enable_i = 1'b1;
        set_zones(4'b1111, 4'b0100, 4'b0000, 4'b0000);
        run_to_done(3, 4'b0100, f_t, i_t, c_t, seen);
        check("z2_done_seen", seen, 1);
        check("z2_fill_ticks", f_t, FILL);
        check("z2_irr_ticks", i_t, SPR);
        check("z2_clean_ticks", c_t, CLN);

        // Round-robin order with all zones dry
        do_reset();
        set_zones(4'b1111, 4'b1111, 4'b0000, 4'b0000);
        exp_a = '{0, 1, 2, 3, 0};
        grant_order(5, got);
        check("rr_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("rr_order", got[i], exp_a[i]);

        // Round-robin with zone 1 masked
        do_reset();
        set_zones(4'b1101, 4'b1111, 4'b0000, 4'b0000);
        exp_b = '{0, 2, 3, 0};
        grant_order(4, got);
        check("rrm_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("rrm_order", got[i], exp_b[i]);

        // Drip zone 1
        do_reset();
        set_zones(4'b1111, 4'b0010, 4'b0010, 4'b0010);
        run_to_done(2, 4'b0010, f_t, i_t, c_t, seen);
        check("drip_done_seen", seen, 1);
        check("drip_irr_ticks", i_t, DRIP);

        // Missing pesticide at end of FILL
        do_reset();
        set_zones(4'b1111, 4'b0001, 4'b0000, 4'b0000);
        pesticide_ok_i = 1'b0;
        run_until_phase(4, 2);
        for (int i = 0; i < 10; i++) begin
            tick_1hz_i = (i % 2 == 0);
            enable_i   = (i % 3 != 0);
            step();
        end
        check("alert_held", alert_np_o, 1);
        check("alert_valve", valve_o, 0);
        enable_i = 1'b1;
        pesticide_ok_i = 1'b1;
        tick_1hz_i = 1'b0;
        step();
        check("alert_release_rem", remaining_o, SPR);

        // Reset in the middle of IRRIGATE, then restart from zone 0
        do_reset();
        set_zones(4'b1111, 4'b0100, 4'b0000, 4'b0000);
        run_until_phase(2, 2);
        for (int i = 0; i < 3; i++) begin tick_1hz_i = 1'b1; step(); end
        do_reset();
        check("midrst_state", state_o, 0);
        check("midrst_valve", valve_o, 0);
        check("midrst_rem", remaining_o, 0);
        set_zones(4'b1111, 4'b1111, 4'b0000, 4'b0000);
        step();
        check("midrst_zone", active_zone_o, 0);

        // Tick coinciding with the grant, and soil drying up mid-IRRIGATE
        do_reset();
        set_zones(4'b1111, 4'b0001, 4'b0000, 4'b0000);
        tick_1hz_i = 1'b1;
        step();
        check("grant_tick_rem", remaining_o, FILL);
        run_until_phase(2, 1);
        soil_dry_i = '0;
        run_to_done(1, 4'b0001, f_t, i_t, c_t, seen);
        check("drop_done_seen", seen, 1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick_1hz_i  = ($urandom_range(0, 2) == 0);
            enable_i    = ($urandom_range(0, 7) != 0);
            zone_mask_i = N'($urandom);
            soil_dry_i  = N'($urandom);
            air_dry_i   = N'($urandom);
            temp_hot_i  = N'($urandom);
            if ($urandom_range(0, 39) == 0) pesticide_ok_i = ~pesticide_ok_i;
            init_pulse  = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
